fp21_norm_pack: RTL
===================

Name: fp21_norm_pack

Overview:
- Back end of the FP21 add datapath. Consumes the adder's unpacked raw result: sign, pre-normalisation exponent, and a 15-bit signed-magnitude sum.
- Normalises via leading-zero count and shift, rounds to nearest even, handles carry, overflow and underflow, and emits a packed 21-bit FP21 word.
- Three-stage valid/ready pipeline; sits directly after the adder's fraction-combine stage.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 12, stored fraction width (hidden bit excluded).
- BIAS, 127, exponent bias (for documentation and tests only; logic is bias-agnostic).

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_sign  in  1  result sign.
- in_exp  in  8  exponent of the larger operand, legal 1..254.
- in_mant  in  15  raw magnitude: [14] carry, [13] integer/hidden, [12:1] fraction, [0] guard.
- in_sticky  in  1  OR of all bits shifted out below the guard bit.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts the result.
- out_fp  out  21  packed result: {sign[20], exp[19:12], frac[11:0]}.
- out_ovf  out  1  result saturated to infinity.
- out_unf  out  1  result flushed to zero, nonzero input only.

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0; out_fp = 0; out_ovf = 0; out_unf = 0.
- Flow control: advance = out_ready | ~out_valid.
  - in_ready = advance (combinational).
  - When advance = 0, every stage holds its data and valid bit.
  - No internal bubbles are squeezed; a single global stall applies.
- Latency: 3 cycles from an accepted beat to out_valid while not stalled. Throughput: 1 beat per cycle.
- S1 (classify):
  - Register inputs.
  - lz = leading-zero count of in_mant[13:0]; range 0..14, where 14 means all zero.
  - is_zero = (in_mant == 0).
  - carry = in_mant[14].
- S2 (shift):
  - Internal exponent e is 10-bit signed.
  - If carry: mantissa shifted right 1, with the old bit0 ORed into sticky; e = exp + 1.
  - Else: mantissa shifted left lz; e = exp - lz.
  - Extract LSB = m[1], guard = m[0], and sticky.
- S3 (round, pack):
  - round_up = guard & (sticky | LSB).
  - mant13 = m[13:1] + round_up.
  - On rounding carry-out (mant13 wraps to 0x0000 with the hidden bit set): frac = 0, e = e + 1.
  - Priority, highest first:
    1. is_zero → out_fp = 21'h00000. Sign forced 0; no flags.
    2. e >= 255 → infinity {sign, 8'hFF, 12'h000}; out_ovf = 1.
    3. e <= 0 → signed zero {sign, 20'h0}; out_unf = 1. No denormals.
    4. Otherwise {sign, e[7:0], frac}.
- Flags: out_ovf and out_unf are valid only with out_valid, and are 0 otherwise.
- Reset mid-operation: in-flight beats are discarded; no output pulse occurs in the reset cycle or the cycle after.
- Simultaneous in_valid with out_ready = 0 and out_valid = 1: the input is not accepted (in_ready = 0); the sender must hold its inputs.

Decomposition:
- Shared package fp21_pkg: FP21 field widths, EXP_MAX = 255, EXP_INF = 8'hFF, BIAS, and a packed-format typedef with sign/exp/frac fields. The adder will adopt it too.
- One sub-module: fp21_lzc14, a combinational 14-bit leading-zero counter with 4-bit output, reusable by the multiplier back end.

Test Plan:
- Normal: sign 0, exp 127, mant 0x2000, sticky 0 → out_fp 0x7F000 after 3 cycles; flags 0.
- Carry: exp 127, mant 0x4000 → 0x80000. Then exp 254, mant 0x4000 → 0xFF000 with out_ovf = 1.
- Cancellation: exp 127, mant 0x0002 → exp 115, out_fp 0x73000. Then exp 5, mant 0x0002 → 0x00000 with out_unf = 1. Then mant 0x0000, sign 1 → 0x00000, no flags.
- Rounding:
  - mant 0x2001, sticky 0 → 0x7F000 (tie, even kept).
  - mant 0x2003 → 0x7F002.
  - mant 0x2001, sticky 1 → 0x7F001.
  - mant 0x3FFF → 0x80000 (round carry).
- Backpressure: stream 8 beats; hold out_ready low for 4 cycles mid-stream → in_ready drops, no beat lost or duplicated, order preserved.
- Reset: assert rst with 3 beats in flight → out_valid = 0 next cycle; first post-reset beat emerges exactly 3 cycles after acceptance.

Source files
------------

// File: rtl/fp21_pkg.sv
// Shared FP21 definitions: field widths, exponent limits and the packed word
// layout. Used by the add back end and intended for the adder/multiplier.
package fp21_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 12;
   localparam int FP_W    = 1 + EXP_W + FRAC_W;
   localparam int MANT_W  = FRAC_W + 3;
   localparam int E_W     = 10;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;
   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp21_t;

   function automatic fp21_t fp21_pack(input logic              sign,
                                       input logic [EXP_W-1:0]  exp,
                                       input logic [FRAC_W-1:0] frac);
      fp21_t w;
      w.sign = sign;
      w.exp  = exp;
      w.frac = frac;
      return w;
   endfunction

endpackage

// File: rtl/fp21_norm_pack_if.sv
// Handshake bundle for the FP21 normalise/pack stage: raw sum in, packed word out.
// master = the surrounding datapath (adder upstream, consumer downstream),
// slave  = the normalise/pack block.
interface fp21_norm_pack_if;
   import fp21_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W-1:0]  in_exp;
   logic [MANT_W-1:0] in_mant;
   logic              in_sticky;
   logic              out_valid;
   logic              out_ready;
   logic [FP_W-1:0]   out_fp;
   logic              out_ovf;
   logic              out_unf;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
      input  in_ready, out_valid, out_fp, out_ovf, out_unf
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
      output in_ready, out_valid, out_fp, out_ovf, out_unf
   );

endinterface

// File: rtl/fp21_lzc14.sv
// Combinational leading-zero counter over 14 bits; returns 14 for an all-zero word.
module fp21_lzc14 (
   input  logic [13:0] mant,
   output logic [3:0]  count
);

   logic found_s;

   // Scan from the MSB down; the first set bit fixes the count.
   always_comb begin
      count   = 4'd14;
      found_s = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found_s && mant[i]) begin
            count   = 4'(13 - i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/fp21_norm_pack.sv
// FP21 add back end: classify -> normalising shift -> round-to-nearest-even and
// pack. Three register stages under one global stall (advance).
module fp21_norm_pack
   import fp21_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   fp21_norm_pack_if.slave bus
);

   logic                  advance_s;
   logic [3:0]            lz_s;

   logic                  s1_valid_r, s1_sign_r, s1_sticky_r, s1_zero_r, s1_carry_r;
   logic [EXP_W-1:0]      s1_exp_r;
   logic [13:0]           s1_mant_r;
   logic [3:0]            s1_lz_r;

   logic [13:0]           s2_m_s;
   logic signed [E_W-1:0] s2_e_s, exp_ext_s;
   logic                  s2_sticky_s;

   logic                  s2_valid_r, s2_sign_r, s2_zero_r, s2_sticky_r;
   logic [13:0]           s2_m_r;
   logic signed [E_W-1:0] s2_e_r;

   logic                  round_up_s, rnd_carry_s, ovf_s, unf_s;
   logic [12:0]           mant13_s;
   logic signed [E_W-1:0] e_fin_s;
   fp21_t                 fp_s;

   logic                  out_valid_r, out_ovf_r, out_unf_r;
   logic [FP_W-1:0]       out_fp_r;

   assign advance_s     = bus.out_ready | ~out_valid_r;
   assign bus.in_ready  = advance_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_fp    = out_fp_r;
   assign bus.out_ovf   = out_ovf_r;
   assign bus.out_unf   = out_unf_r;

   fp21_lzc14 u_lzc (
      .mant  (bus.in_mant[13:0]),
      .count (lz_s)
   );

   // S1: capture the beat together with its leading-zero count and class.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_sign_r   <= 1'b0;
         s1_sticky_r <= 1'b0;
         s1_zero_r   <= 1'b0;
         s1_carry_r  <= 1'b0;
         s1_exp_r    <= 8'h00;
         s1_mant_r   <= 14'h0000;
         s1_lz_r     <= 4'd0;
      end else if (advance_s) begin
         s1_valid_r  <= bus.in_valid;
         s1_sign_r   <= bus.in_sign;
         s1_sticky_r <= bus.in_sticky;
         s1_zero_r   <= (bus.in_mant == 15'h0000);
         s1_carry_r  <= bus.in_mant[14];
         s1_exp_r    <= bus.in_exp;
         s1_mant_r   <= bus.in_mant[13:0];
         s1_lz_r     <= lz_s;
      end
   end

   // S2 shift: a carry moves right by one (bit0 joins sticky), otherwise the
   // leading one is pulled up to the hidden-bit position.
   always_comb begin
      exp_ext_s   = $signed({2'b00, s1_exp_r});
      s2_m_s      = 14'h0000;
      s2_e_s      = 10'sd0;
      s2_sticky_s = 1'b0;
      if (s1_carry_r) begin
         s2_m_s      = {1'b1, s1_mant_r[13:1]};
         s2_sticky_s = s1_sticky_r | s1_mant_r[0];
         s2_e_s      = exp_ext_s + 10'sd1;
      end else begin
         s2_m_s      = s1_mant_r << s1_lz_r;
         s2_sticky_s = s1_sticky_r;
         s2_e_s      = exp_ext_s - $signed({6'd0, s1_lz_r});
      end
   end

   // S2: register the normalised mantissa and signed working exponent.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r  <= 1'b0;
         s2_sign_r   <= 1'b0;
         s2_zero_r   <= 1'b0;
         s2_sticky_r <= 1'b0;
         s2_m_r      <= 14'h0000;
         s2_e_r      <= 10'sd0;
      end else if (advance_s) begin
         s2_valid_r  <= s1_valid_r;
         s2_sign_r   <= s1_sign_r;
         s2_zero_r   <= s1_zero_r;
         s2_sticky_r <= s2_sticky_s;
         s2_m_r      <= s2_m_s;
         s2_e_r      <= s2_e_s;
      end
   end

   // S3 round-to-nearest-even, then zero > overflow > underflow > normal.
   always_comb begin
      round_up_s  = s2_m_r[0] & (s2_sticky_r | s2_m_r[1]);
      mant13_s    = s2_m_r[13:1] + {12'd0, round_up_s};
      rnd_carry_s = s2_m_r[13] & (mant13_s == 13'd0);
      ovf_s       = 1'b0;
      unf_s       = 1'b0;
      if (rnd_carry_s) begin
         e_fin_s = s2_e_r + 10'sd1;
      end else begin
         e_fin_s = s2_e_r;
      end
      if (s2_zero_r) begin
         fp_s = fp21_pack(1'b0, 8'h00, 12'h000);
      end else if (e_fin_s >= $signed(10'(EXP_MAX))) begin
         fp_s  = fp21_pack(s2_sign_r, EXP_INF, 12'h000);
         ovf_s = 1'b1;
      end else if (e_fin_s <= 10'sd0) begin
         fp_s  = fp21_pack(s2_sign_r, 8'h00, 12'h000);
         unf_s = 1'b1;
      end else begin
         fp_s = fp21_pack(s2_sign_r, e_fin_s[7:0], mant13_s[11:0]);
      end
   end

   // S3: registered outputs; word and flags read as zero whenever no beat is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_fp_r    <= 21'h000000;
         out_ovf_r   <= 1'b0;
         out_unf_r   <= 1'b0;
      end else if (advance_s) begin
         out_valid_r <= s2_valid_r;
         if (s2_valid_r) begin
            out_fp_r  <= fp_s;
            out_ovf_r <= ovf_s;
            out_unf_r <= unf_s;
         end else begin
            out_fp_r  <= 21'h000000;
            out_ovf_r <= 1'b0;
            out_unf_r <= 1'b0;
         end
      end
   end

endmodule
